// File: rtl/velocimetro_periodo_pkg.sv
// Shared types and constants for the wheel-speed period meter.
// K converts a cycle count into a speed: cm/s, or km/h x10 (cm/s * 0.36).
package velocimetro_periodo_pkg;

  typedef enum logic [1:0] {
    STOP    = 2'd0,
    MEASURE = 2'd1,
    DIVIDE  = 2'd2,
    UPDATE  = 2'd3
  } state_e;

  localparam logic MODE_CMS   = 1'b0;
  localparam logic MODE_KMH10 = 1'b1;

  function automatic longint unsigned k_for_mode(input logic mode,
                                                 input longint unsigned clk_hz);
    if (mode == MODE_KMH10) return (clk_hz * 36) / 100;
    return clk_hz;
  endfunction

endpackage

// File: rtl/velocimetro_periodo_if.sv
// Pulse/configuration inputs and speed/status outputs of the period meter.
// The master drives the magnet pulse and wheel setup; the slave is the meter.
interface velocimetro_periodo_if #(
  parameter int CIRC_W  = 16,
  parameter int SPEED_W = 16
);
  logic               pulse_in;
  logic [CIRC_W-1:0]  circumference;
  logic               mode;
  logic [SPEED_W-1:0] speed;
  logic               speed_valid;
  logic               stopped;
  logic               saturated;
  logic               busy;

  modport master (
    output pulse_in, circumference, mode,
    input  speed, speed_valid, stopped, saturated, busy
  );

  modport slave (
    input  pulse_in, circumference, mode,
    output speed, speed_valid, stopped, saturated, busy
  );
endinterface

// File: rtl/velocimetro_periodo_divisor_secuencial.sv
// Restoring divider: one quotient bit per cycle, NUM_W cycles after start_i.
// done_o is high during the final iteration, so quotient_o is final on the next cycle.
module divisor_secuencial #(
  parameter int NUM_W = 30,
  parameter int DEN_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [NUM_W-1:0] numerator_i,
  input  logic [DEN_W-1:0] denominator_i,
  output logic [NUM_W-1:0] quotient_o,
  output logic             done_o
);

  localparam int CNT_W = $clog2(NUM_W + 1);

  logic [NUM_W-1:0] num_q;
  logic [DEN_W:0]   rem_q;
  logic [DEN_W-1:0] den_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;

  logic [DEN_W:0]   rem_shift;
  logic [DEN_W:0]   rem_next;
  logic             fits;

  // num_q shifts the dividend out at the top while quotient bits enter at the bottom
  always_comb begin
    rem_shift = {rem_q[DEN_W-1:0], num_q[NUM_W-1]};
    fits      = rem_shift >= {1'b0, den_q};
    rem_next  = fits ? (rem_shift - {1'b0, den_q}) : rem_shift;
    done_o    = run_q && (cnt_q == CNT_W'(1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      num_q <= '0;
      rem_q <= '0;
      den_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start_i) begin
      num_q <= numerator_i;
      rem_q <= '0;
      den_q <= denominator_i;
      cnt_q <= CNT_W'(NUM_W);
      run_q <= 1'b1;
    end else if (run_q) begin
      num_q <= {num_q[NUM_W-2:0], fits};
      rem_q <= rem_next;
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) run_q <= 1'b0;
    end
  end

  assign quotient_o = num_q;

endmodule

// File: rtl/velocimetro_periodo.sv
// Wheel-speed meter: counts cycles between magnet pulses, divides circumference*K
// by the period, saturates, averages over 2^AVG_LOG2 samples and detects standstill.
module velocimetro_periodo
  import velocimetro_periodo_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int CIRC_W         = 16,
  parameter int PERIOD_W       = 32,
  parameter int SPEED_W        = 16,
  parameter int AVG_LOG2       = 2,
  parameter int TIMEOUT_CYC    = 100_000_000,
  parameter int MIN_PERIOD_CYC = 500_000
) (
  input logic                  clock,
  input logic                  reset,
  velocimetro_periodo_if.slave vel_if
);

  localparam int KW    = $clog2(CLK_HZ + 1);
  localparam int NUM_W = CIRC_W + KW;
  localparam int AVG_N = 1 << AVG_LOG2;
  localparam int PTR_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int SUM_W = SPEED_W + AVG_LOG2;

  localparam logic [KW-1:0]       K_CMS   = KW'(k_for_mode(MODE_CMS, longint'(CLK_HZ)));
  localparam logic [KW-1:0]       K_KMH10 = KW'(k_for_mode(MODE_KMH10, longint'(CLK_HZ)));
  localparam logic [PERIOD_W-1:0] TIMEOUT = PERIOD_W'(TIMEOUT_CYC);
  localparam logic [PERIOD_W-1:0] MIN_P   = PERIOD_W'(MIN_PERIOD_CYC);
  localparam logic [SPEED_W-1:0]  SPEED_MAX = '1;

  state_e               state_q, state_d;
  logic [PERIOD_W-1:0]  cnt_q, cnt_d;
  logic [SPEED_W-1:0]   hist_q [AVG_N];
  logic [SPEED_W-1:0]   hist_d [AVG_N];
  logic [SUM_W-1:0]     sum_q, sum_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic                 first_q, first_d;
  logic [SPEED_W-1:0]   speed_q, speed_d;
  logic                 valid_q, valid_d;
  logic                 stopped_q, stopped_d;
  logic                 sat_q, sat_d;

  logic [PERIOD_W-1:0]  elapsed;
  logic                 timeout;
  logic                 accept;
  logic [KW-1:0]        k_sel;
  logic [NUM_W-1:0]     numerator;
  logic                 div_start;
  logic                 div_done;
  logic [NUM_W-1:0]     div_quotient;
  logic                 q_sat;
  logic [SPEED_W-1:0]   sample;

  // elapsed counts the current cycle too, so pulses N edges apart give a period of N
  always_comb begin
    elapsed   = (cnt_q >= TIMEOUT) ? TIMEOUT : (cnt_q + PERIOD_W'(1));
    timeout   = (state_q == MEASURE) && (elapsed == TIMEOUT);
    accept    = vel_if.pulse_in &&
                ((state_q == STOP) || ((state_q == MEASURE) && (elapsed >= MIN_P)));
    k_sel     = (vel_if.mode == MODE_KMH10) ? K_KMH10 : K_CMS;
    numerator = NUM_W'(vel_if.circumference) * NUM_W'(k_sel);
    q_sat     = div_quotient > NUM_W'(SPEED_MAX);
    sample    = q_sat ? SPEED_MAX : div_quotient[SPEED_W-1:0];
  end

  // The divider registers the numerator and period at start, which freezes mode/circumference
  divisor_secuencial #(
    .NUM_W (NUM_W),
    .DEN_W (PERIOD_W)
  ) u_div (
    .clk_i         (clock),
    .rst_i         (reset),
    .start_i       (div_start),
    .numerator_i   (numerator),
    .denominator_i (elapsed),
    .quotient_o    (div_quotient),
    .done_o        (div_done)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = accept ? '0 : elapsed;
    hist_d    = hist_q;
    sum_d     = sum_q;
    ptr_d     = ptr_q;
    first_d   = first_q;
    speed_d   = speed_q;
    valid_d   = 1'b0;
    stopped_d = stopped_q;
    sat_d     = sat_q;
    div_start = 1'b0;

    unique case (state_q)
      STOP: begin
        if (accept) state_d = MEASURE;
      end
      MEASURE: begin
        if (timeout) begin
          // A pulse landing on the timeout edge starts the next measurement
          state_d   = accept ? MEASURE : STOP;
          speed_d   = '0;
          valid_d   = 1'b1;
          stopped_d = 1'b1;
          sum_d     = '0;
          ptr_d     = '0;
          first_d   = 1'b1;
          for (int i = 0; i < AVG_N; i++) hist_d[i] = '0;
        end else if (accept) begin
          div_start = 1'b1;
          state_d   = DIVIDE;
        end
      end
      DIVIDE: begin
        if (div_done) state_d = UPDATE;
      end
      UPDATE: begin
        if (first_q) begin
          for (int i = 0; i < AVG_N; i++) hist_d[i] = sample;
          sum_d   = SUM_W'(sample) << AVG_LOG2;
          first_d = 1'b0;
        end else begin
          hist_d[ptr_q] = sample;
          sum_d         = sum_q - SUM_W'(hist_q[ptr_q]) + SUM_W'(sample);
        end
        if (AVG_LOG2 == 0) ptr_d = '0;
        else               ptr_d = ptr_q + PTR_W'(1);
        speed_d   = sum_d[SUM_W-1 -: SPEED_W];
        sat_d     = q_sat;
        valid_d   = 1'b1;
        stopped_d = 1'b0;
        state_d   = MEASURE;
      end
      default: state_d = STOP;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= STOP;
      cnt_q     <= '0;
      sum_q     <= '0;
      ptr_q     <= '0;
      first_q   <= 1'b1;
      speed_q   <= '0;
      valid_q   <= 1'b0;
      stopped_q <= 1'b1;
      sat_q     <= 1'b0;
      for (int i = 0; i < AVG_N; i++) hist_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hist_q    <= hist_d;
      sum_q     <= sum_d;
      ptr_q     <= ptr_d;
      first_q   <= first_d;
      speed_q   <= speed_d;
      valid_q   <= valid_d;
      stopped_q <= stopped_d;
      sat_q     <= sat_d;
    end
  end

  assign vel_if.speed       = speed_q;
  assign vel_if.speed_valid = valid_q;
  assign vel_if.stopped     = stopped_q;
  assign vel_if.saturated   = sat_q;
  assign vel_if.busy        = (state_q == DIVIDE);

endmodule

// File: tb/tb_velocimetro_periodo.sv
// Directed and randomized bench for velocimetro_periodo with a queue-based
// speed/averaging model; all stimulus is driven on the falling clock edge.
module tb_velocimetro_periodo;

  localparam int CLK_HZ    = 10_000;
  localparam int CIRC_W    = 16;
  localparam int PERIOD_W  = 32;
  localparam int SPEED_W   = 16;
  localparam int AVG_LOG2  = 2;
  localparam int TIMEOUT   = 20_000;
  localparam int MINP      = 100;
  localparam int NUM_W     = CIRC_W + $clog2(CLK_HZ + 1);
  localparam int LAT       = NUM_W + 2;
  localparam int AVG_N     = 1 << AVG_LOG2;
  localparam longint SMAX  = (longint'(1) << SPEED_W) - 1;

  logic clock = 1'b0;
  logic reset = 1'b1;

  int checks      = 0;
  int failures    = 0;
  int cyc         = 0;
  int pulseEdge   = 0;
  int strobes     = 0;
  int lastLatency = 0;

  longint hist[$];
  bit     modelFirst   = 1'b1;
  bit     modelRunning = 1'b0;

  velocimetro_periodo_if #(.CIRC_W(CIRC_W), .SPEED_W(SPEED_W)) ifc ();

  velocimetro_periodo #(
    .CLK_HZ         (CLK_HZ),
    .CIRC_W         (CIRC_W),
    .PERIOD_W       (PERIOD_W),
    .SPEED_W        (SPEED_W),
    .AVG_LOG2       (AVG_LOG2),
    .TIMEOUT_CYC    (TIMEOUT),
    .MIN_PERIOD_CYC (MINP)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .vel_if (ifc)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(negedge clock);
    if (ifc.speed_valid === 1'b1) begin
      strobes++;
      lastLatency = cyc - pulseEdge + 1;
    end
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) step();
  endtask

  task automatic pulseNow(input bit accepted);
    ifc.pulse_in = 1'b1;
    if (accepted) pulseEdge = cyc + 1;
    step();
    ifc.pulse_in = 1'b0;
  endtask

  task automatic doReset();
    ifc.pulse_in = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic modelStop();
    modelRunning = 1'b0;
    modelFirst   = 1'b1;
    hist.delete();
  endtask

  // speed = circumference * K / period, clipped, then mean of the last AVG_N samples
  task automatic modelPulse(input int circ, input bit md, input int period,
                            output bit produce, output longint expSpeed, output bit expSat);
    longint k, q, s, total;
    produce  = 1'b0;
    expSpeed = 0;
    expSat   = 1'b0;
    if (!modelRunning) begin
      modelRunning = 1'b1;
    end else begin
      k      = md ? (longint'(CLK_HZ) * 36) / 100 : longint'(CLK_HZ);
      q      = (longint'(circ) * k) / period;
      expSat = (q > SMAX);
      s      = expSat ? SMAX : q;
      if (modelFirst) begin
        hist.delete();
        repeat (AVG_N) hist.push_back(s);
        modelFirst = 1'b0;
      end else begin
        hist.push_back(s);
        void'(hist.pop_front());
      end
      total = 0;
      foreach (hist[i]) total += hist[i];
      expSpeed = total / AVG_N;
      produce  = 1'b1;
    end
  endtask

  task automatic applyStimulus(input int gap, input int circ, input bit md, input string tag);
    bit     produce;
    bit     expSat;
    longint expSpeed;
    int     s0;
    ifc.circumference = CIRC_W'(circ);
    ifc.mode          = md;
    if (modelRunning) waitUntil(pulseEdge + gap - 1);
    s0 = strobes;
    modelPulse(circ, md, gap, produce, expSpeed, expSat);
    pulseNow(1'b1);
    step();
    checkOutput({tag, "_busy"}, 64'(ifc.busy), produce ? 64'd1 : 64'd0);
    // Inputs scrambled mid-division must not leak into this sample
    ifc.circumference = CIRC_W'($urandom);
    ifc.mode          = 1'($urandom);
    if (produce) begin
      for (int k = 0; k < LAT + 8 && strobes == s0; k++) step();
      checkOutput({tag, "_strobes"}, 64'(strobes - s0), 64'd1);
      checkOutput({tag, "_latency"}, 64'(lastLatency), 64'(LAT));
      checkOutput({tag, "_speed"}, 64'(ifc.speed), 64'(expSpeed));
      checkOutput({tag, "_sat"}, 64'(ifc.saturated), 64'(expSat));
      checkOutput({tag, "_stopped"}, 64'(ifc.stopped), 64'd0);
    end
  endtask

  initial begin
    int s0;
    int oldEdge;
    ifc.pulse_in      = 1'b0;
    ifc.circumference = '0;
    ifc.mode          = 1'b0;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();
    checkOutput("rst_speed", 64'(ifc.speed), 64'd0);
    checkOutput("rst_valid", 64'(ifc.speed_valid), 64'd0);
    checkOutput("rst_stopped", 64'(ifc.stopped), 64'd1);
    checkOutput("rst_sat", 64'(ifc.saturated), 64'd0);
    checkOutput("rst_busy", 64'(ifc.busy), 64'd0);
    modelStop();

    $display("[TB] idle after reset");
    s0 = strobes;
    repeat (30_000) step();
    checkOutput("idle_strobes", 64'(strobes - s0), 64'd0);
    checkOutput("idle_stopped", 64'(ifc.stopped), 64'd1);
    checkOutput("idle_speed", 64'(ifc.speed), 64'd0);

    $display("[TB] cm/s, 5000 then 2500-cycle periods");
    applyStimulus(0, 200, 1'b0, "t2_first");
    applyStimulus(5000, 200, 1'b0, "t2_p5000");
    checkOutput("t2_400", 64'(ifc.speed), 64'd400);
    applyStimulus(2500, 200, 1'b0, "t3_a");
    checkOutput("t3_500", 64'(ifc.speed), 64'd500);
    applyStimulus(2500, 200, 1'b0, "t3_b");
    checkOutput("t3_600", 64'(ifc.speed), 64'd600);
    applyStimulus(2500, 200, 1'b0, "t3_c");
    checkOutput("t3_700", 64'(ifc.speed), 64'd700);

    $display("[TB] km/h x10");
    doReset();
    modelStop();
    applyStimulus(0, 200, 1'b1, "t4_first");
    applyStimulus(5000, 200, 1'b1, "t4_kmh");
    checkOutput("t4_144", 64'(ifc.speed), 64'd144);

    $display("[TB] saturation and lockout");
    doReset();
    modelStop();
    applyStimulus(0, 65535, 1'b0, "t5_first");
    applyStimulus(MINP, 65535, 1'b0, "t5_sat");
    checkOutput("t5_65535", 64'(ifc.speed), 64'd65535);
    checkOutput("t5_sat1", 64'(ifc.saturated), 64'd1);
    s0 = strobes;
    waitUntil(pulseEdge + 49);
    pulseNow(1'b0);
    applyStimulus(200, 100, 1'b0, "t5_lock");
    checkOutput("t5_50401", 64'(ifc.speed), 64'd50401);
    checkOutput("t5_sat0", 64'(ifc.saturated), 64'd0);
    checkOutput("t5_lock_strobes", 64'(strobes - s0), 64'd1);

    $display("[TB] randomized periods");
    doReset();
    modelStop();
    applyStimulus(0, 1000, 1'b0, "rnd_first");
    for (int n = 0; n < 16; n++) begin
      int circ;
      circ = ($urandom_range(0, 7) == 0) ? 65535 : int'($urandom_range(1, 4000));
      applyStimulus(int'($urandom_range(MINP, 700)), circ, 1'($urandom),
                    $sformatf("rnd%0d", n));
    end

    $display("[TB] timeout with pulse on the timeout edge");
    s0 = strobes;
    oldEdge = pulseEdge;
    ifc.circumference = 16'd150;
    ifc.mode          = 1'b0;
    waitUntil(oldEdge + TIMEOUT - 1);
    pulseNow(1'b1);
    checkOutput("t6_edge", 64'(cyc), 64'(oldEdge + TIMEOUT));
    checkOutput("t6_strobes", 64'(strobes - s0), 64'd1);
    checkOutput("t6_speed0", 64'(ifc.speed), 64'd0);
    checkOutput("t6_stopped", 64'(ifc.stopped), 64'd1);
    modelStop();
    modelRunning = 1'b1;
    applyStimulus(300, 150, 1'b0, "t6_restart");
    checkOutput("t6_5000", 64'(ifc.speed), 64'd5000);

    $display("[TB] reset during division");
    ifc.circumference = 16'd150;
    ifc.mode          = 1'b0;
    waitUntil(pulseEdge + 299);
    pulseNow(1'b1);
    step();
    step();
    checkOutput("t6_busy_div", 64'(ifc.busy), 64'd1);
    reset = 1'b1;
    step();
    checkOutput("t6_busy_rst", 64'(ifc.busy), 64'd0);
    reset = 1'b0;
    s0 = strobes;
    repeat (LAT + 10) step();
    checkOutput("t6_abort_strobes", 64'(strobes - s0), 64'd0);
    checkOutput("t6_abort_stopped", 64'(ifc.stopped), 64'd1);
    checkOutput("t6_abort_speed", 64'(ifc.speed), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
